// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types and command-field layout for the ALU operand sequencer.
// Imported by the sequencer and by anything that builds command bytes for it.
package alu_operand_sequencer_pkg;

  localparam int unsigned DataWDefault = 8;
  localparam int unsigned ResWDefault  = 2 * DataWDefault;

  // Command byte layout: select bits at the bottom, the rest reserved-zero.
  localparam int unsigned S0_BIT   = 0;
  localparam int unsigned S1_BIT   = 1;
  localparam int unsigned RSVD_MSB = 7;
  localparam int unsigned RSVD_LSB = 2;

  typedef enum logic [2:0] {
    StCmd,
    StLoadA,
    StLoadB,
    StLoadC,
    StExec,
    StHold
  } seq_state_e;

  function automatic logic cmd_is_legal(input logic [RSVD_MSB:0] cmd);
    return cmd[RSVD_MSB:RSVD_LSB] == '0;
  endfunction

endpackage

// File: rtl/alu_operand_sequencer.sv
// Byte-stream front end for the three-operand ALU: collects a command and three operands,
// holds them on registered outputs, captures the ALU result and hands it off downstream.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned RES_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_c,
  output logic              alu_s0,
  output logic              alu_s1,
  input  logic [RES_W-1:0]  alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              cmd_err,
  output logic [7:0]        op_count
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              s0_q, s0_d;
  logic              s1_q, s1_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              in_xfer;

  assign in_ready = (state_q == StCmd) || (state_q == StLoadA) ||
                    (state_q == StLoadB) || (state_q == StLoadC);
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    res_d   = res_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      StCmd: begin
        if (in_xfer) begin
          // A rejected command leaves the previous select in place.
          if (cmd_is_legal(in_data[RSVD_MSB:0])) begin
            s0_d    = in_data[S0_BIT];
            s1_d    = in_data[S1_BIT];
            state_d = StLoadA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoadA: begin
        if (in_xfer) begin
          a_d     = in_data;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        if (in_xfer) begin
          b_d     = in_data;
          state_d = StLoadC;
        end
      end
      StLoadC: begin
        if (in_xfer) begin
          c_d     = in_data;
          state_d = StExec;
        end
      end
      StExec: begin
        // Operands have been stable on the ALU for this whole cycle.
        res_d   = alu_out;
        state_d = StHold;
      end
      StHold: begin
        if (res_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StCmd;
        end
      end
      default: state_d = StCmd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCmd;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_c     = c_q;
  assign alu_s0    = s0_q;
  assign alu_s1    = s1_q;
  assign res_valid = (state_q == StHold);
  assign res_data  = res_q;
  assign cmd_err   = err_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: a behavioural ALU beside the DUT, table-driven operations
// with a result scoreboard, plus hand-written hold, command-error and mid-sequence reset cases.
module tb_alu_operand_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  alu_a, alu_b, alu_c;
  logic        alu_s0, alu_s1;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        cmd_err;
  logic [7:0]  op_count;

  int          n_checks;
  int          n_errors;
  int          exp_cnt;
  logic [15:0] exp_q[$];
  logic        prev_valid;
  logic [15:0] prev_data;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[5];

  alu_operand_sequencer #(
    .DATA_W(8),
    .RES_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_c    (alu_c),
    .alu_s0   (alu_s0),
    .alu_s1   (alu_s1),
    .alu_out  (alu_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .cmd_err  (cmd_err),
    .op_count (op_count)
  );

  // Stand-in for the real ALU that sits beside the sequencer.
  function automatic logic [15:0] alu_fn(input logic s1, input logic s0, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
    logic [15:0] az, bz, cz;
    az = {8'h00, a};
    bz = {8'h00, b};
    cz = {8'h00, c};
    case ({s1, s0})
      2'b00:   return az * bz;
      2'b10:   return az - cz;
      2'b01:   return (az ~^ bz) ~^ cz;
      default: return a[0] ? (bz + cz) : (bz - cz);
    endcase
  endfunction

  assign alu_out = alu_fn(alu_s1, alu_s0, alu_a, alu_b, alu_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare the result on every handshake, and watch res_data stay put.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(res_data), 32'hDEAD_0000);
      end else begin
        check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && res_valid && prev_valid) begin
      check("res_data_stable", 32'(res_data), 32'(prev_data));
    end
    prev_valid = rst_n && res_valid;
    prev_data  = res_data;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic start_op(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [15:0] res);
    exp_q.push_back(res);
    send_byte(cmd);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    check("exec_in_ready", 32'(in_ready), 32'd0);
    check("exec_res_valid", 32'(res_valid), 32'd0);
  endtask

  task automatic wait_result();
    @(posedge clk);
    #1;
    check("res_valid_latency", 32'(res_valid), 32'd1);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    if (res_ready) begin
      @(posedge clk);
      #1;
      exp_cnt++;
      check("post_hs_res_valid", 32'(res_valid), 32'd0);
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      check("op_count", 32'(op_count), 32'(exp_cnt));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_alu_abc", {8'h00, alu_a, alu_b, alu_c}, 32'd0);
    check("rst_alu_sel", {30'd0, alu_s1, alu_s0}, 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{cmd: 8'h00, a: 8'hFF, b: 8'hFF, c: 8'h00, res: 16'hFE01};
    vecs[1] = '{cmd: 8'h02, a: 8'h05, b: 8'h00, c: 8'h07, res: 16'hFFFE};
    vecs[2] = '{cmd: 8'h01, a: 8'hF0, b: 8'h0F, c: 8'h00, res: 16'h00FF};
    vecs[3] = '{cmd: 8'h03, a: 8'h01, b: 8'h10, c: 8'h20, res: 16'h0030};
    vecs[4] = '{cmd: 8'h03, a: 8'h00, b: 8'h10, c: 8'h20, res: 16'hFFF0};

    n_checks   = 0;
    n_errors   = 0;
    exp_cnt    = 0;
    prev_valid = 1'b0;
    prev_data  = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    res_ready  = 1'b0;
    rst_n      = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: downstream always ready, so each handshake lands on the first HOLD edge.
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].res);
      wait_result();
    end

    // Back-pressure: five stalled HOLD cycles with in_valid pushing junk.
    res_ready = 1'b0;
    start_op(8'h00, 8'h03, 8'h04, 8'h09, 16'h000C);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(posedge clk);
      #1;
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_alu", {8'h00, alu_a, alu_b, alu_c}, 32'h0003_0409);
      check("stall_op_count", 32'(op_count), 32'(exp_cnt));
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt++;
    check("release_op_count", 32'(op_count), 32'(exp_cnt));
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Reserved bit set: byte dropped, select untouched (still 00 from the stalled op).
    send_byte(8'h84);
    check("cmd_err_pulse", 32'(cmd_err), 32'd1);
    check("cmd_err_in_ready", 32'(in_ready), 32'd1);
    check("cmd_err_sel_kept", {30'd0, alu_s1, alu_s0}, 32'd0);
    @(posedge clk);
    #1;
    check("cmd_err_drop", 32'(cmd_err), 32'd0);
    start_op(8'h00, 8'h12, 8'h10, 8'h77, 16'h0120);
    wait_result();

    // Reset while waiting for operand B.
    send_byte(8'h01);
    send_byte(8'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_op(8'h02, 8'h10, 8'h33, 8'h01, 16'h000F);
    wait_result();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
